// File: rtl/pipe_id_ie_reg.sv
// ID->IE pipeline register: captures decoded control, operands and register addresses,
// inserts bubbles on hazard flush or squashed ID, and counts flush bubbles (saturating).
module pipe_id_ie_reg #(
  parameter int DATA_W       = 32,
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    hold_i,
  input  logic                    flush_i,
  input  logic                    cnt_clr_i,
  input  logic                    valid_id_i,
  input  logic                    reg_write_id_i,
  input  logic                    mem_to_reg_id_i,
  input  logic                    mem_write_id_i,
  input  logic                    alu_src_id_i,
  input  logic                    reg_dst_id_i,
  input  logic [2:0]              alu_ctrl_id_i3,
  input  logic [DATA_W-1:0]       rd1_id_i,
  input  logic [DATA_W-1:0]       rd2_id_i,
  input  logic [DATA_W-1:0]       imm_id_i,
  input  logic [4:0]              rs_id_i5,
  input  logic [4:0]              rt_id_i5,
  input  logic [4:0]              rd_id_i5,
  output logic                    valid_ie_o,
  output logic                    reg_write_ie_o,
  output logic                    mem_to_reg_ie_o,
  output logic                    mem_write_ie_o,
  output logic                    alu_src_ie_o,
  output logic                    reg_dst_ie_o,
  output logic [2:0]              alu_ctrl_ie_o3,
  output logic [DATA_W-1:0]       rd1_ie_o,
  output logic [DATA_W-1:0]       rd2_ie_o,
  output logic [DATA_W-1:0]       imm_ie_o,
  output logic [4:0]              rs_ie_o5,
  output logic [4:0]              rt_ie_o5,
  output logic [4:0]              rd_ie_o5,
  output logic [4:0]              dst_reg_addr_ie_o5,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_dst;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
  } stage_t;

  localparam logic [BUBBLE_CNT_W-1:0] CNT_MAX = '1;

  stage_t                  stage_q;
  stage_t                  stage_load;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;

  always_comb begin
    stage_load            = '0;
    stage_load.valid      = 1'b1;
    stage_load.reg_write  = reg_write_id_i;
    stage_load.mem_to_reg = mem_to_reg_id_i;
    stage_load.mem_write  = mem_write_id_i;
    stage_load.alu_src    = alu_src_id_i;
    stage_load.reg_dst    = reg_dst_id_i;
    stage_load.alu_ctrl   = alu_ctrl_id_i3;
    stage_load.rd1        = rd1_id_i;
    stage_load.rd2        = rd2_id_i;
    stage_load.imm        = imm_id_i;
    stage_load.rs         = rs_id_i5;
    stage_load.rt         = rt_id_i5;
    stage_load.rd         = rd_id_i5;
  end

  // A bubble is all zeros so that reg 0 addresses never match in the hazard unit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (!hold_i) begin
      if (flush_i || !valid_id_i) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_load;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bubble_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      bubble_cnt_q <= '0;
    end else if (!hold_i && flush_i && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_q <= bubble_cnt_q + BUBBLE_CNT_W'(1);
    end
  end

  assign valid_ie_o         = stage_q.valid;
  assign reg_write_ie_o     = stage_q.reg_write;
  assign mem_to_reg_ie_o    = stage_q.mem_to_reg;
  assign mem_write_ie_o     = stage_q.mem_write;
  assign alu_src_ie_o       = stage_q.alu_src;
  assign reg_dst_ie_o       = stage_q.reg_dst;
  assign alu_ctrl_ie_o3     = stage_q.alu_ctrl;
  assign rd1_ie_o           = stage_q.rd1;
  assign rd2_ie_o           = stage_q.rd2;
  assign imm_ie_o           = stage_q.imm;
  assign rs_ie_o5           = stage_q.rs;
  assign rt_ie_o5           = stage_q.rt;
  assign rd_ie_o5           = stage_q.rd;
  assign dst_reg_addr_ie_o5 = stage_q.reg_dst ? stage_q.rd : stage_q.rt;
  assign bubble_cnt_o       = bubble_cnt_q;

endmodule
